branch_predictor: RTL and testbench

- Dynamic branch predictor that consumes resolved branch outcomes from the branch decision logic (take_branch plus the computed target) and supplies predicted direction and target for the fetch PC.
- Direct-mapped table of 2^IDX_BITS entries. Each entry holds a valid bit, a tag, a 32-bit target and a 2-bit saturating counter.
- Sits beside pc_next_logic. It gives a lookup result on the fetch side and is trained on the resolve side.

---
 rtl/branch_predictor.sv | 147 ++++++++++++++
 tb/tb_branch_predictor.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Direct-mapped dynamic branch predictor. Each of the 2^IDX_BITS entries holds
// a valid bit, a tag, a 32-bit target and a 2-bit saturating counter. The
// fetch side gets a zero-latency lookup from the registered table. The resolve
// side trains the table on the rising edge of clk.
//
// Optional feature: define BRANCH_PRED_STATS_EN to build the saturating
// branch and mispredict counters. Without it the stat ports are tied to zero
// and no counter flops exist.
//
// Ports:
//   clk              in   clock, all state updates on rising edge
//   rst              in   synchronous active-high reset
//   flush            in   clears every valid bit on the next edge
//   lk_pc            in   fetch PC to look up
//   lk_hit           out  entry valid and tag matches lk_pc
//   lk_taken         out  predicted taken (hit and counter MSB set)
//   lk_target        out  stored target if predicted taken, else lk_pc+4
//   upd_valid        in   resolved branch present this cycle
//   upd_pc           in   PC of the resolved branch
//   upd_taken        in   actual outcome
//   upd_target       in   actual branch target
//   upd_pred_taken   in   direction that was predicted for this branch
//   upd_pred_target  in   next PC that was predicted for this branch
//   upd_mispredict   out  misprediction flag for this cycle's update
//   stat_branches    out  count of resolved branches (optional)
//   stat_mispredicts out  count of mispredictions (optional)
// -----------------------------------------------------------------------------
module branch_predictor #(
  parameter int IDX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] lk_pc,
  output logic        lk_hit,
  output logic        lk_taken,
  output logic [31:0] lk_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        upd_mispredict,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  localparam int TAG_BITS = 30 - IDX_BITS;
  localparam int NUM_ENT  = 1 << IDX_BITS;

  logic                r_valid  [NUM_ENT];
  logic [TAG_BITS-1:0] r_tag    [NUM_ENT];
  logic [31:0]         r_target [NUM_ENT];
  logic [1:0]          r_ctr    [NUM_ENT];

  logic [IDX_BITS-1:0] w_lk_idx;
  logic [TAG_BITS-1:0] w_lk_tag;
  logic [IDX_BITS-1:0] w_upd_idx;
  logic [TAG_BITS-1:0] w_upd_tag;
  logic                w_upd_hit;
  logic                w_unused_pc_lsbs;

  // Instruction PCs are word aligned; the byte-offset bits carry no meaning.
  assign w_unused_pc_lsbs = ^{lk_pc[1:0], upd_pc[1:0]};

  assign w_lk_idx  = lk_pc[IDX_BITS+1:2];
  assign w_lk_tag  = lk_pc[31:IDX_BITS+2];
  assign w_upd_idx = upd_pc[IDX_BITS+1:2];
  assign w_upd_tag = upd_pc[31:IDX_BITS+2];

  // Lookup reads the registered table, so a same-cycle update to the same
  // index is only visible from the following cycle.
  assign lk_hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign lk_taken  = lk_hit && r_ctr[w_lk_idx][1];
  assign lk_target = lk_taken ? r_target[w_lk_idx] : (lk_pc + 32'd4);

  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

  // A target mismatch only matters when the branch was actually taken.
  assign upd_mispredict = upd_valid &&
                          ((upd_pred_taken != upd_taken) ||
                           (upd_taken && (upd_pred_target != upd_target)));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENT; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
    end else if (flush) begin
      // Counters and targets survive a flush; only the entries are invalidated.
      for (int i = 0; i < NUM_ENT; i++) begin
        r_valid[i] <= 1'b0;
      end
    end else if (upd_valid) begin
      if (w_upd_hit) begin
        if (upd_taken) begin
          if (r_ctr[w_upd_idx] != 2'b11) begin
            r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] + 2'b01;
          end
          r_target[w_upd_idx] <= upd_target;
        end else if (r_ctr[w_upd_idx] != 2'b00) begin
          r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] - 2'b01;
        end
      end else if (upd_taken) begin
        // Taken miss allocates (or evicts an alias) as weakly taken.
        r_valid[w_upd_idx]  <= 1'b1;
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= upd_target;
        r_ctr[w_upd_idx]    <= 2'b10;
      end
    end
  end

`ifdef BRANCH_PRED_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispredicts;

  // Counted on flush cycles too; the update is still a resolved branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else if (upd_valid) begin
      if (r_stat_branches != 32'hFFFF_FFFF) begin
        r_stat_branches <= r_stat_branches + 32'd1;
      end
      if (upd_mispredict && (r_stat_mispredicts != 32'hFFFF_FFFF)) begin
        r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
      end
    end
  end

  assign stat_branches    = r_stat_branches;
  assign stat_mispredicts = r_stat_mispredicts;
`else
  assign stat_branches    = 32'h0;
  assign stat_mispredicts = 32'h0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] lk_pc;
  logic        lk_hit;
  logic        lk_taken;
  logic [31:0] lk_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        upd_mispredict;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_predictor #(.IDX_BITS(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .lk_pc            (lk_pc),
    .lk_hit           (lk_hit),
    .lk_taken         (lk_taken),
    .lk_target        (lk_target),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_pred_taken   (upd_pred_taken),
    .upd_pred_target  (upd_pred_target),
    .upd_mispredict   (upd_mispredict),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  // Reference model: one record per table slot, counter kept as a plain int.
  bit          m_valid [16];
  longint      m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  longint      m_br;
  longint      m_mp;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic longint tag_of(input logic [31:0] pc);
    return longint'(pc) / 64;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit m_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] pc);
    longint nxt;
    nxt = (longint'(pc) + 4) % 64'h1_0000_0000;
    return m_taken(pc) ? m_tgt[idx_of(pc)] : nxt[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs, compare all outputs against the model, then
  // advance the model to what the coming rising edge must produce.
  task automatic step(input bit r, input bit fl, input logic [31:0] lk,
                      input bit uv, input logic [31:0] upc, input bit ut,
                      input logic [31:0] utg, input bit upt, input logic [31:0] uptg);
    bit     mis;
    int     i;
    longint cap;
    @(negedge clk);
    rst = r; flush = fl; lk_pc = lk;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utg;
    upd_pred_taken = upt; upd_pred_target = uptg;
    #1;
    mis = uv && ((upt != ut) || (ut && (uptg != utg)));
    chk("lk_hit",    {31'b0, lk_hit},    {31'b0, m_hit(lk)});
    chk("lk_taken",  {31'b0, lk_taken},  {31'b0, m_taken(lk)});
    chk("lk_target", lk_target,          m_target(lk));
    chk("upd_mispredict", {31'b0, upd_mispredict}, {31'b0, mis});
`ifdef BRANCH_PRED_STATS_EN
    chk("stat_branches",    stat_branches,    m_br[31:0]);
    chk("stat_mispredicts", stat_mispredicts, m_mp[31:0]);
`else
    chk("stat_branches",    stat_branches,    32'h0);
    chk("stat_mispredicts", stat_mispredicts, 32'h0);
`endif
    cap = 64'hFFFF_FFFF;
    if (r) begin
      for (int k = 0; k < 16; k++) begin
        m_valid[k] = 0; m_tag[k] = 0; m_tgt[k] = 0; m_ctr[k] = 1;
      end
      m_br = 0; m_mp = 0;
    end else begin
      if (uv) begin
        if (m_br < cap) m_br++;
        if (mis && m_mp < cap) m_mp++;
      end
      if (fl) begin
        for (int k = 0; k < 16; k++) m_valid[k] = 0;
      end else if (uv) begin
        i = idx_of(upc);
        if (m_hit(upc)) begin
          if (ut) begin
            m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
            m_tgt[i] = utg;
          end else begin
            m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
          end
        end else if (ut) begin
          m_valid[i] = 1; m_tag[i] = tag_of(upc); m_tgt[i] = utg; m_ctr[i] = 2;
        end
      end
    end
  endtask

  task automatic look(input logic [31:0] lk);
    step(0, 0, lk, 0, 32'h0, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic upd(input logic [31:0] lk, input logic [31:0] pc, input bit t,
                     input logic [31:0] tg, input bit pt, input logic [31:0] ptg);
    step(0, 0, lk, 1, pc, t, tg, pt, ptg);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc;
    pc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
    if ($urandom_range(0, 15) == 0) pc = 32'hFFFF_FFFC;
    return pc;
  endfunction

  initial begin
    logic [31:0] pc, tg, ptg;
    bit t, pt, fl, r;

    step(1, 0, 32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    step(1, 0, 32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h0);

    // Empty table after reset, including the PC+4 wrap.
    look(32'h100);
    chk("reset_hit", {31'b0, lk_hit}, 32'h0);
    chk("reset_target", lk_target, 32'h104);
    look(32'hFFFF_FFFC);
    chk("wrap_target", lk_target, 32'h0);

    // Allocation on a taken miss.
    upd(32'h100, 32'h100, 1, 32'h80, 0, 32'h104);
    chk("alloc_mispredict", {31'b0, upd_mispredict}, 32'h1);
    look(32'h100);
    chk("alloc_target", lk_target, 32'h80);

    // Counter saturation up, down, then back up by one.
    upd(32'h100, 32'h100, 1, 32'h80, 1, 32'h80);
    upd(32'h100, 32'h100, 1, 32'h80, 1, 32'h80);
    upd(32'h100, 32'h100, 0, 32'h80, 1, 32'h80);
    upd(32'h100, 32'h100, 0, 32'h80, 1, 32'h80);
    upd(32'h100, 32'h100, 0, 32'h80, 0, 32'h104);
    chk("ctr01_not_taken", {31'b0, lk_taken}, 32'h0);
    upd(32'h100, 32'h100, 0, 32'h80, 0, 32'h104);
    upd(32'h100, 32'h100, 1, 32'h80, 0, 32'h104);
    look(32'h100);
    chk("ctr_floor_hit", {31'b0, lk_hit}, 32'h1);
    chk("ctr_floor_target", lk_target, 32'h104);

    // Aliasing at the same index.
    upd(32'h100, 32'h140, 0, 32'h0, 0, 32'h144);
    look(32'h100);
    chk("alias_nt_keeps", {31'b0, lk_hit}, 32'h1);
    upd(32'h100, 32'h140, 1, 32'h200, 0, 32'h144);
    look(32'h100);
    chk("alias_evicted", {31'b0, lk_hit}, 32'h0);
    look(32'h140);
    chk("alias_target", lk_target, 32'h200);

    // Read-before-write on the same index.
    upd(32'h100, 32'h100, 1, 32'h80, 0, 32'h104);
    upd(32'h100, 32'h100, 1, 32'h300, 1, 32'h80);
    chk("rbw_old_target", lk_target, 32'h80);
    look(32'h100);
    chk("rbw_new_target", lk_target, 32'h300);

    // Flush with a coincident update.
    step(0, 1, 32'h100, 1, 32'h180, 1, 32'h400, 0, 32'h184);
    look(32'h100);
    chk("flush_hit", {31'b0, lk_hit}, 32'h0);
    look(32'h180);
    chk("flush_drop", {31'b0, lk_hit}, 32'h0);

    // Stats: five updates, two mispredicts, then reset.
    step(1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    upd(32'h0, 32'h10, 1, 32'h40, 0, 32'h14);
    upd(32'h0, 32'h10, 1, 32'h40, 1, 32'h40);
    upd(32'h0, 32'h10, 0, 32'h40, 1, 32'h40);
    upd(32'h0, 32'h20, 0, 32'h0, 0, 32'h24);
    upd(32'h0, 32'h10, 1, 32'h40, 1, 32'h40);
    look(32'h0);
`ifdef BRANCH_PRED_STATS_EN
    chk("stat5", stat_branches, 32'd5);
    chk("stat2", stat_mispredicts, 32'd2);
`else
    chk("stat_off_br", stat_branches, 32'd0);
    chk("stat_off_mp", stat_mispredicts, 32'd0);
`endif
    step(1, 0, 32'h0, 1, 32'h10, 1, 32'h40, 0, 32'h0);
    look(32'h0);
    chk("stat_rst_br", stat_branches, 32'd0);
    chk("stat_rst_mp", stat_mispredicts, 32'd0);

    // Randomized traffic over a small PC pool to force aliasing.
    for (int n = 0; n < 400; n++) begin
      pc = rand_pc();
      t  = $urandom_range(0, 1);
      tg = {$urandom_range(0, 7), 4'h0} << 4;
      if ($urandom_range(0, 1) != 0) begin
        pt = m_taken(pc); ptg = m_target(pc);
      end else begin
        pt = $urandom_range(0, 1); ptg = t ? tg : pc + 32'd4;
      end
      fl = ($urandom_range(0, 19) == 0);
      r  = ($urandom_range(0, 99) == 0);
      step(r, fl, rand_pc(), ($urandom_range(0, 3) != 0), pc, t, tg, pt, ptg);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
